out_ctrl: RTL and testbench
===========================

OUT_CTRL -- requirements
Module: out_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning result element width.
REQ-002 SHALL have parameter ADDR_W, default 16, meaning result RAM word-address width.
REQ-003 SHALL have these ports: clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have these ports: rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have these ports: start  in  1  one-cycle pulse beginning one sub-matrix tile.
REQ-006 SHALL have these ports: sub_scale_M  in  8  tile rows; sub_scale_P  in  8  tile columns (1..8).
REQ-007 SHALL have these ports: row_base  in  ADDR_W  tile first row; col_base  in  ADDR_W  tile first column; scale_P  in  ADDR_W  full-matrix row pitch.
REQ-008 SHALL have these ports: accumulate  in  1  1 = add incoming element to the stored value; 0 = overwrite.
REQ-009 SHALL have these ports: out_ctrl_ready  out  1  may pop one element from the aligner this cycle.
REQ-010 SHALL have these ports: valid  in  1  element beat; data  in  DATA_W  element, valid one cycle after valid.
REQ-011 SHALL have these ports: ram_re  out  1, ram_raddr  out  ADDR_W, ram_rdata  in  DATA_W (1-cycle read latency).
REQ-012 SHALL have these ports: ram_we  out  1, ram_waddr  out  ADDR_W, ram_wdata  out  DATA_W.
REQ-013 SHALL have these ports: busy  out  1; done  out  1  one-cycle tile completion pulse; overflow  out  1  sticky error.

Function
REQ-014 SHALL implement states IDLE, RUN, DRAIN; start in IDLE latches all tile inputs and goes to RUN; total = M*P (16-bit).
REQ-015 SHALL, when start arrives with total = 0, stay in IDLE and pulse done in the next cycle.
REQ-016 SHALL ignore start outside IDLE.
REQ-017 SHALL drive out_ctrl_ready = RUN && (acc_cnt + valid < total), acc_cnt being the number of valid beats accepted so far.
REQ-018 SHALL treat elements as row-major: column c counts 0..P-1, then row r increments.
REQ-019 SHALL compute address = (row_base + r)*scale_P + col_base + c using a running row-start register advanced by scale_P (no multiplier), modulo 2^ADDR_W.
REQ-020 SHALL, for a valid beat accepted in cycle t, assert ram_re with that address in cycle t when accumulate=1 (ram_re=0 otherwise).
REQ-021 SHALL assert ram_we in cycle t+2, with ram_wdata = data + ram_rdata (modulo 2^DATA_W) when accumulate=1, or data otherwise; data and ram_rdata are sampled in t+1.
REQ-022 SHALL support one beat per cycle with no bubbles, forwarding a write in flight to the same address when the read and the write coincide.
REQ-023 SHALL move from RUN to DRAIN on the last accepted beat, and from DRAIN to IDLE after the last write; done SHALL pulse in the cycle after the last ram_we.
REQ-024 SHALL drop valid beats accepted outside RUN or beyond total and set overflow, which stays set until rst.
REQ-025 SHALL drive busy = (state != IDLE).

Reset
REQ-026 SHALL, while rst=1, force state IDLE, all counters 0, out_ctrl_ready/ram_re/ram_we/done/busy/overflow 0, and addresses/wdata 0; any write in flight is discarded.
REQ-027 SHALL accept start in the first cycle after rst deasserts.

Structure
REQ-028 SHALL place the state encoding, DATA_W/ADDR_W defaults and the 8-column limit in the shared TPU package.
REQ-029 SHALL use one sub-module, out_addr_gen, which holds the r/c counters and the running row-start address.
REQ-030 SHALL register all outputs except out_ctrl_ready and ram_raddr.

Verification
REQ-031 SHALL test M=2, P=3, row_base=0, col_base=0, scale_P=3, accumulate=0, data 1..6 -> writes at addresses 0..5 with values 1..6; done 1 cycle after the 6th write.
REQ-032 SHALL test M=1, P=2, row_base=4, col_base=2, scale_P=10, accumulate=1, RAM preloaded 100 at 42 and 43, data 5,7 -> 105 at 42 and 107 at 43.
REQ-033 SHALL test M=8, P=8, valid held high for 64 cycles -> 64 writes in consecutive cycles; out_ctrl_ready low after the 63rd accept plus in-flight beat; overflow=0.
REQ-034 SHALL test 65 valid beats against total 64 -> 64 writes; overflow=1 and stays 1.
REQ-035 SHALL test start with M=0 -> done pulses next cycle, no RAM access, busy stays 0.
REQ-036 SHALL test rst asserted after the 3rd beat of a 4x4 tile -> all outputs 0 next cycle; a fresh tile then completes correctly.

Source files
------------

// File: rtl/out_ctrl_pkg.sv
// Shared definitions for the output controller: state encoding, default widths
// and the tile column limit.
package out_ctrl_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 16;
  localparam int MAX_COLS   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/out_addr_gen.sv
// Row-major address walker for one result tile.
// Addresses advance by adding the row pitch; there is no per-element multiply.
module out_addr_gen
  import out_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [7:0]        sub_m,
  input  logic [7:0]        sub_p,
  input  logic [ADDR_W-1:0] row_base,
  input  logic [ADDR_W-1:0] col_base,
  input  logic [ADDR_W-1:0] scale_P,
  output logic [ADDR_W-1:0] addr,
  output logic              tile_last
);

  logic [7:0]        r_reg, c_reg, last_row_reg, last_col_reg;
  logic [ADDR_W-1:0] row_start_reg, col_base_reg, pitch_reg;
  logic [ADDR_W-1:0] row_start_init;

  // The first row start costs one product per tile; every later row is a single add.
  assign row_start_init = row_base * scale_P;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg         <= '0;
      c_reg         <= '0;
      last_row_reg  <= '0;
      last_col_reg  <= '0;
      row_start_reg <= '0;
      col_base_reg  <= '0;
      pitch_reg     <= '0;
    end else if (load) begin
      r_reg         <= '0;
      c_reg         <= '0;
      last_row_reg  <= sub_m - 8'd1;
      last_col_reg  <= sub_p - 8'd1;
      row_start_reg <= row_start_init;
      col_base_reg  <= col_base;
      pitch_reg     <= scale_P;
    end else if (step) begin
      if (c_reg == last_col_reg) begin
        c_reg         <= '0;
        r_reg         <= r_reg + 8'd1;
        row_start_reg <= row_start_reg + pitch_reg;
      end else begin
        c_reg <= c_reg + 8'd1;
      end
    end
  end

  assign addr      = row_start_reg + col_base_reg + ADDR_W'(c_reg);
  assign tile_last = (r_reg == last_row_reg) && (c_reg == last_col_reg);

endmodule

// File: rtl/out_ctrl.sv
// Result write-back controller: takes element beats from the aligner, optionally
// accumulates them with the stored value, and writes them to the result RAM.
module out_ctrl
  import out_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        sub_scale_M,
  input  logic [7:0]        sub_scale_P,
  input  logic [ADDR_W-1:0] row_base,
  input  logic [ADDR_W-1:0] col_base,
  input  logic [ADDR_W-1:0] scale_P,
  input  logic              accumulate,
  output logic              out_ctrl_ready,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  state_t            state_reg, state_next;
  logic [15:0]       total_reg, total_in;
  logic [16:0]       acc_cnt_reg, wr_cnt_reg;
  logic              accum_reg;
  logic [7:0]        p_eff;
  logic              start_go, load, accept, drop, last_write, tile_last;
  logic [ADDR_W-1:0] gen_addr;

  logic              p1_valid_reg, p1_acc_reg;
  logic [ADDR_W-1:0] p1_addr_reg;
  logic              old_we_reg;
  logic [ADDR_W-1:0] old_addr_reg;
  logic [DATA_W-1:0] old_data_reg;

  logic              hist_we   [2];
  logic [ADDR_W-1:0] hist_addr [2];
  logic [DATA_W-1:0] hist_data [2];
  logic [1:0]        hit;
  logic [DATA_W-1:0] rd_val, sum;

  assign p_eff    = (sub_scale_P > 8'(MAX_COLS)) ? 8'(MAX_COLS) : sub_scale_P;
  assign total_in = 16'(sub_scale_M) * 16'(p_eff);
  assign start_go = !rst && start && (state_reg == IDLE);
  assign load     = start_go && (total_in != 16'd0);
  assign accept   = !rst && valid && (state_reg == RUN) && (acc_cnt_reg < {1'b0, total_reg});
  assign drop     = !rst && valid && !accept;
  assign last_write = ram_we && ((wr_cnt_reg + 17'd1) == {1'b0, total_reg});

  // The read must issue in the same cycle as the beat, so these three are combinational.
  assign out_ctrl_ready = !rst && (state_reg == RUN) &&
                          ((acc_cnt_reg + 17'(valid)) < {1'b0, total_reg});
  assign ram_re    = accept && accum_reg;
  assign ram_raddr = rst ? '0 : gen_addr;

  out_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (accept),
    .sub_m     (sub_scale_M),
    .sub_p     (p_eff),
    .row_base  (row_base),
    .col_base  (col_base),
    .scale_P   (scale_P),
    .addr      (gen_addr),
    .tile_last (tile_last)
  );

  // Slot 0 is the write landing now, slot 1 the one from last cycle; neither
  // is visible in the read data returned for the beat in stage 1.
  assign hist_we[0]   = ram_we;
  assign hist_addr[0] = ram_waddr;
  assign hist_data[0] = ram_wdata;
  assign hist_we[1]   = old_we_reg;
  assign hist_addr[1] = old_addr_reg;
  assign hist_data[1] = old_data_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign hit[gi] = hist_we[gi] && (hist_addr[gi] == p1_addr_reg);
    end
  endgenerate

  always_comb begin
    rd_val = ram_rdata;
    if (hit[1]) rd_val = hist_data[1];
    if (hit[0]) rd_val = hist_data[0];
  end

  assign sum = data + (p1_acc_reg ? rd_val : '0);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (load) state_next = RUN;
      RUN:     if (accept && tile_last) state_next = DRAIN;
      DRAIN:   if (last_write) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      total_reg    <= '0;
      acc_cnt_reg  <= '0;
      wr_cnt_reg   <= '0;
      accum_reg    <= 1'b0;
      p1_valid_reg <= 1'b0;
      p1_acc_reg   <= 1'b0;
      p1_addr_reg  <= '0;
      ram_we       <= 1'b0;
      ram_waddr    <= '0;
      ram_wdata    <= '0;
      old_we_reg   <= 1'b0;
      old_addr_reg <= '0;
      old_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      busy      <= (state_next != IDLE);
      done      <= (start_go && (total_in == 16'd0)) || ((state_reg == DRAIN) && last_write);
      overflow  <= overflow | drop;
      if (load) begin
        total_reg   <= total_in;
        acc_cnt_reg <= '0;
        wr_cnt_reg  <= '0;
        accum_reg   <= accumulate;
      end else begin
        if (accept) acc_cnt_reg <= acc_cnt_reg + 17'd1;
        if (ram_we) wr_cnt_reg <= wr_cnt_reg + 17'd1;
      end
      p1_valid_reg <= accept;
      p1_acc_reg   <= accum_reg;
      p1_addr_reg  <= gen_addr;
      ram_we       <= p1_valid_reg;
      if (p1_valid_reg) begin
        ram_waddr <= p1_addr_reg;
        ram_wdata <= sum;
      end
      old_we_reg   <= ram_we;
      old_addr_reg <= ram_waddr;
      old_data_reg <= ram_wdata;
    end
  end

endmodule

// File: tb/tb_out_ctrl.sv
// Directed self-checking bench for out_ctrl with a 1-cycle-latency RAM model.
module tb_out_ctrl;

  localparam int DW = 32;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst, start, accumulate, valid;
  logic [7:0]    sub_scale_M, sub_scale_P;
  logic [AW-1:0] row_base, col_base, scale_P;
  logic [DW-1:0] data, ram_rdata, ram_wdata;
  logic          out_ctrl_ready, ram_re, ram_we, busy, done, overflow;
  logic [AW-1:0] ram_raddr, ram_waddr;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int re_cnt   = 0;
  int busy_cnt = 0;
  int start_cyc;
  logic          last_ready;
  logic [DW-1:0] data_pipe;
  logic          pre_we;
  logic [9:0]    pre_addr;
  logic [DW-1:0] pre_data;
  logic [DW-1:0] mem [0:1023];

  logic [AW-1:0] wq_addr [$];
  logic [DW-1:0] wq_data [$];
  int            wq_cyc  [$];
  int            done_cyc[$];

  always #5 clk = ~clk;

  out_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .sub_scale_M(sub_scale_M), .sub_scale_P(sub_scale_P),
    .row_base(row_base), .col_base(col_base), .scale_P(scale_P),
    .accumulate(accumulate), .out_ctrl_ready(out_ctrl_ready),
    .valid(valid), .data(data),
    .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .busy(busy), .done(done), .overflow(overflow)
  );

  // Result RAM: registered read, write at the clock edge, read returns old data.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_re) ram_rdata <= mem[ram_raddr[9:0]];
    if (ram_we) mem[ram_waddr[9:0]] <= ram_wdata;
    if (pre_we) mem[pre_addr] <= pre_data;
  end

  always @(negedge clk) begin
    if (ram_we) begin
      wq_addr.push_back(ram_waddr);
      wq_data.push_back(ram_wdata);
      wq_cyc.push_back(cyc);
      $display("write addr=%0d data=%0d cyc=%0d", ram_waddr, ram_wdata, cyc);
    end
    if (done) done_cyc.push_back(cyc);
    if (ram_re) re_cnt <= re_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic tick(input logic v, input logic [DW-1:0] d);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; valid = v; data = data_pipe; data_pipe = d;
    @(negedge clk);
    last_ready = out_ctrl_ready;
  endtask

  task automatic start_tile(input logic [7:0] m, input logic [7:0] p, input logic [AW-1:0] rb,
                            input logic [AW-1:0] cb, input logic [AW-1:0] sp, input logic acc);
    @(posedge clk); #1;
    rst = 1'b0; sub_scale_M = m; sub_scale_P = p; row_base = rb; col_base = cb;
    scale_P = sp; accumulate = acc; start = 1'b1; valid = 1'b0;
    data = data_pipe; data_pipe = '0;
    @(negedge clk);
    start_cyc = cyc;
  endtask

  task automatic apply_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst = 1'b1; start = 1'b0; valid = 1'b0; data = data_pipe; data_pipe = '0;
    end
    @(negedge clk);
  endtask

  task automatic preload(input logic [9:0] a, input logic [DW-1:0] v);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_addr = a; pre_data = v;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset(3);
    n_checks++;
    if ({out_ctrl_ready, ram_re, ram_we, done, busy, overflow} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {out_ctrl_ready, ram_re, ram_we, done, busy, overflow});
    end
    n_checks++;
    if ({ram_raddr, ram_waddr, ram_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_addr_data: got raddr=%0d waddr=%0d wdata=%0d expected 0",
               ram_raddr, ram_waddr, ram_wdata);
    end
    $display("test_reset done");
  endtask

  task automatic test_store;
    int wb, db, nw;
    wb = wq_addr.size(); db = done_cyc.size();
    start_tile(8'd2, 8'd3, 16'd0, 16'd0, 16'd3, 1'b0);
    for (int i = 1; i <= 6; i++) tick(1'b1, DW'(i));
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL store_busy: got %b expected 1", busy); end
    for (int i = 0; i < 6; i++) tick(1'b0, '0);
    nw = wq_addr.size() - wb;
    n_checks++;
    if (nw != 6) begin
      n_fail++; $display("FAIL store_count: got %0d expected 6", nw);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (wq_addr[wb+i] !== AW'(i) || wq_data[wb+i] !== DW'(i + 1)) begin
          n_fail++;
          $display("FAIL store_write%0d: got addr=%0d data=%0d expected addr=%0d data=%0d",
                   i, wq_addr[wb+i], wq_data[wb+i], i, i + 1);
        end
      end
      n_checks++;
      if (wq_cyc[wb+5] - wq_cyc[wb] != 5) begin
        n_fail++; $display("FAIL store_spacing: got %0d expected 5", wq_cyc[wb+5] - wq_cyc[wb]);
      end
      n_checks++;
      if (done_cyc.size() - db != 1 || done_cyc[db] != wq_cyc[wb+5] + 1) begin
        n_fail++;
        $display("FAIL store_done: got %0d pulses expected 1 pulse one cycle after last write",
                 done_cyc.size() - db);
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL store_idle: got busy=%b expected 0", busy); end
    $display("test_store done");
  endtask

  task automatic test_accumulate;
    int wb, rb, nw;
    preload(10'd42, 32'd100);
    preload(10'd43, 32'd100);
    wb = wq_addr.size(); rb = re_cnt;
    start_tile(8'd1, 8'd2, 16'd4, 16'd2, 16'd10, 1'b1);
    tick(1'b1, 32'd5);
    tick(1'b1, 32'd7);
    for (int i = 0; i < 5; i++) tick(1'b0, '0);
    nw = wq_addr.size() - wb;
    n_checks++;
    if (nw != 2) begin
      n_fail++; $display("FAIL acc_count: got %0d expected 2", nw);
    end else begin
      n_checks++;
      if (wq_addr[wb] !== 16'd42 || wq_data[wb] !== 32'd105) begin
        n_fail++; $display("FAIL acc_write0: got addr=%0d data=%0d expected addr=42 data=105",
                           wq_addr[wb], wq_data[wb]);
      end
      n_checks++;
      if (wq_addr[wb+1] !== 16'd43 || wq_data[wb+1] !== 32'd107) begin
        n_fail++; $display("FAIL acc_write1: got addr=%0d data=%0d expected addr=43 data=107",
                           wq_addr[wb+1], wq_data[wb+1]);
      end
    end
    n_checks++;
    if (re_cnt - rb != 2) begin n_fail++; $display("FAIL acc_reads: got %0d expected 2", re_cnt - rb); end
    $display("test_accumulate done");
  endtask

  task automatic test_full_tile;
    int wb, nw, bad;
    logic rdy [64];
    wb = wq_addr.size();
    start_tile(8'd8, 8'd8, 16'd0, 16'd0, 16'd8, 1'b0);
    for (int i = 0; i < 64; i++) begin
      tick(1'b1, DW'(i + 1));
      rdy[i] = last_ready;
    end
    for (int i = 0; i < 6; i++) tick(1'b0, '0);
    n_checks++;
    if (rdy[0] !== 1'b1 || rdy[62] !== 1'b1 || rdy[63] !== 1'b0) begin
      n_fail++; $display("FAIL full_ready: got beat0=%b beat62=%b beat63=%b expected 1 1 0",
                         rdy[0], rdy[62], rdy[63]);
    end
    nw = wq_addr.size() - wb;
    n_checks++;
    if (nw != 64) begin
      n_fail++; $display("FAIL full_count: got %0d expected 64", nw);
    end else begin
      bad = 0;
      for (int i = 0; i < 64; i++)
        if (wq_addr[wb+i] !== AW'(i) || wq_data[wb+i] !== DW'(i + 1)) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL full_contents: got %0d wrong writes expected 0", bad); end
      n_checks++;
      if (wq_cyc[wb+63] - wq_cyc[wb] != 63) begin
        n_fail++; $display("FAIL full_back_to_back: got span %0d expected 63", wq_cyc[wb+63] - wq_cyc[wb]);
      end
    end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_overflow: got %b expected 0", overflow); end
    $display("test_full_tile done");
  endtask

  task automatic test_overflow;
    int wb, nw;
    wb = wq_addr.size();
    start_tile(8'd8, 8'd8, 16'd0, 16'd0, 16'd8, 1'b0);
    for (int i = 0; i < 65; i++) tick(1'b1, DW'(i + 100));
    for (int i = 0; i < 4; i++) tick(1'b0, '0);
    nw = wq_addr.size() - wb;
    n_checks++;
    if (nw != 64) begin n_fail++; $display("FAIL ovf_count: got %0d expected 64", nw); end
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    for (int i = 0; i < 8; i++) tick(1'b0, '0);
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    $display("test_overflow done");
  endtask

  task automatic test_empty_tile;
    int wb, db, rb, bb;
    wb = wq_addr.size(); db = done_cyc.size(); rb = re_cnt; bb = busy_cnt;
    start_tile(8'd0, 8'd3, 16'd0, 16'd0, 16'd3, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, '0);
    n_checks++;
    if (done_cyc.size() - db != 1) begin
      n_fail++; $display("FAIL empty_done_count: got %0d expected 1", done_cyc.size() - db);
    end else begin
      n_checks++;
      if (done_cyc[db] != start_cyc + 1) begin
        n_fail++; $display("FAIL empty_done_time: got cycle %0d expected %0d", done_cyc[db], start_cyc + 1);
      end
    end
    n_checks++;
    if (wq_addr.size() != wb || re_cnt != rb || busy_cnt != bb) begin
      n_fail++; $display("FAIL empty_activity: got writes=%0d reads=%0d busy=%0d expected 0 0 0",
                         wq_addr.size() - wb, re_cnt - rb, busy_cnt - bb);
    end
    $display("test_empty_tile done");
  endtask

  task automatic test_mid_reset;
    int wb, db, nw, bad;
    start_tile(8'd4, 8'd4, 16'd0, 16'd0, 16'd4, 1'b0);
    for (int i = 1; i <= 3; i++) tick(1'b1, DW'(i));
    apply_reset(2);
    n_checks++;
    if ({out_ctrl_ready, ram_re, ram_we, done, busy, overflow} !== 6'b0) begin
      n_fail++;
      $display("FAIL midrst_ctrl: got %b expected 000000",
               {out_ctrl_ready, ram_re, ram_we, done, busy, overflow});
    end
    n_checks++;
    if ({ram_raddr, ram_waddr, ram_wdata} !== '0) begin
      n_fail++;
      $display("FAIL midrst_addr_data: got raddr=%0d waddr=%0d wdata=%0d expected 0",
               ram_raddr, ram_waddr, ram_wdata);
    end
    wb = wq_addr.size(); db = done_cyc.size();
    start_tile(8'd4, 8'd4, 16'd0, 16'd0, 16'd4, 1'b0);
    for (int i = 0; i < 16; i++) tick(1'b1, DW'(i + 10));
    for (int i = 0; i < 6; i++) tick(1'b0, '0);
    nw = wq_addr.size() - wb;
    n_checks++;
    if (nw != 16) begin
      n_fail++; $display("FAIL midrst_count: got %0d expected 16", nw);
    end else begin
      bad = 0;
      for (int i = 0; i < 16; i++)
        if (wq_addr[wb+i] !== AW'(i) || wq_data[wb+i] !== DW'(i + 10)) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL midrst_contents: got %0d wrong writes expected 0", bad); end
      n_checks++;
      if (done_cyc.size() - db != 1 || done_cyc[db] != wq_cyc[wb+15] + 1) begin
        n_fail++; $display("FAIL midrst_done: got %0d pulses expected 1 pulse after last write",
                           done_cyc.size() - db);
      end
    end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL midrst_overflow: got %b expected 0", overflow); end
    $display("test_mid_reset done");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0; accumulate = 1'b0;
    data = '0; data_pipe = '0; sub_scale_M = '0; sub_scale_P = '0;
    row_base = '0; col_base = '0; scale_P = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0; last_ready = 1'b0; start_cyc = 0;
    test_reset();
    test_store();
    test_accumulate();
    test_full_tile();
    test_overflow();
    test_empty_tile();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
